instr_encoder: RTL and testbench
================================

# instr_encoder

Encodes RV32I instructions of the four classes the main decoder handles (load word, store word, R-type ALU, branch-if-equal) from field-level requests into 32-bit machine words. It writes them sequentially into instruction memory through a one-entry registered output stage with valid/ready handshakes. It is used by test and boot infrastructure to build programs for the single-cycle core without an external assembler.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- Clear  input  1  synchronous restart: address to 0, Err and Full cleared, pending word dropped
- InValid  input  1  request valid
- InReady  output  1  request accepted when InValid & InReady
- Kind  input  2  00 LW, 01 SW, 10 R-type, 11 BEQ
- AluSel  input  3  R-type op: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT; other codes illegal
- Rd, Rs1, Rs2  input  5 each  register indices; unused fields ignored
- Imm  input  13  signed immediate (byte offset for BEQ)
- WrValid  output  1  word pending for memory
- WrReady  input  1  memory accepts word when WrValid & WrReady
- WrAddr  output  ADDR_W  word address of the pending word
- WrData  output  32  encoded instruction
- Count  output  ADDR_W+1  words written since reset/Clear
- Full  output  1  Count == 2^ADDR_W
- Err  output  1  sticky, set on a rejected request

## Operation
- Encodings (opcode in [6:0]):
  - LW: Imm[11:0] | Rs1 | 010 | Rd | 0000011
  - SW: Imm[11:5] | Rs2 | Rs1 | 010 | Imm[4:0] | 0100011
  - R: funct7 | Rs2 | Rs1 | funct3 | Rd | 0110011. ADD 0000000/000, SUB 0100000/000, AND 0000000/111, OR 0000000/110, SLT 0000000/010
  - BEQ: Imm[12] | Imm[10:5] | Rs2 | Rs1 | 000 | Imm[4:1] | Imm[11] | 1100011
- States:
  - EMPTY (WrValid=0)
  - PENDING (WrValid=1)
  - FULL (Full=1, WrValid=0)
- Transitions:
  - EMPTY→PENDING on a legal accepted request.
  - PENDING→EMPTY on a write handshake with no new legal request.
  - PENDING→PENDING on a write handshake plus a legal request in the same cycle; the new word loads with no bubble.
  - Any→FULL when a write handshake makes Count reach 2^ADDR_W.
  - FULL→EMPTY only on Clear.
- InReady = !rst & !Full & (!WrValid | WrReady).
- WrAddr = Count[ADDR_W-1:0]. Count increments by 1 per write handshake.
- Illegal AluSel on an accepted R-type request: the request is consumed, no word is produced, Err is set, and Count is unchanged.
- Clear has priority over InValid and WrReady in the same cycle: the pending word is discarded and Count is not incremented.

## Timing
- Reset values: WrValid 0, WrData 0, WrAddr 0, Count 0, Full 0, Err 0. InReady is 0 while rst is high and 1 on the first cycle after rst falls.
- Latency: request accepted at edge N → WrValid=1 with WrData valid after edge N.
- WrData and WrAddr are registered and held stable while WrValid & !WrReady.
- Sustained throughput is 1 word/cycle when WrReady is held high.
- Reset asserted mid-transfer aborts immediately; the pending word is lost.

## Configuration
- INSTR_ENC_RANGE_CHECK_EN defined:
  - LW/SW requests with Imm[12] != Imm[11] (outside −2048..2047) are rejected.
  - BEQ requests with Imm[0]=1 are rejected.
  - A rejection sets Err and produces no word.
- Not defined: no range checks. Immediates are truncated to the field bits shown above, BEQ Imm[0] is ignored, and Err is set only by an illegal AluSel.

## Test plan
- LW Rd=5 Rs1=2 Imm=8, WrReady=1 → WrData 0x00812283 at WrAddr 0, then Count=1.
- SW Rs2=6 Rs1=2 Imm=12 → 0x00612623; BEQ Rs1=1 Rs2=2 Imm=−4 → 0xFE208EE3.
- Back-to-back R-type ADD then SUB, Rd=3 Rs1=1 Rs2=2, with WrReady low for 3 cycles → 0x002081B3 held stable at WrAddr 0 while stalled, then 0x402081B3 at WrAddr 1; InReady low during the stall.
- AluSel=111 → no WrValid, Err=1, Count unchanged. With INSTR_ENC_RANGE_CHECK_EN: LW Imm=2048 → rejected, Err=1.
- ADDR_W=2, five legal requests → four writes at addresses 0–3, Full=1, InReady=0; Clear → Count=0, Full=0, Err=0.
- rst asserted while WrValid=1 → all outputs 0 asynchronously; after release, the next request writes at WrAddr 0.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus for instr_encoder.
// slave is the encoder's view; master is the requester/memory side.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              Clear;
  logic              InValid;
  logic              InReady;
  logic [1:0]        Kind;
  logic [2:0]        AluSel;
  logic [4:0]        Rd;
  logic [4:0]        Rs1;
  logic [4:0]        Rs2;
  logic [12:0]       Imm;
  logic              WrValid;
  logic              WrReady;
  logic [ADDR_W-1:0] WrAddr;
  logic [31:0]       WrData;
  logic [ADDR_W:0]   Count;
  logic              Full;
  logic              Err;

  modport slave (
    input  Clear, InValid, Kind, AluSel, Rd, Rs1, Rs2, Imm, WrReady,
    output InReady, WrValid, WrAddr, WrData, Count, Full, Err
  );

  modport master (
    output Clear, InValid, Kind, AluSel, Rd, Rs1, Rs2, Imm, WrReady,
    input  InReady, WrValid, WrAddr, WrData, Count, Full, Err
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes LW/SW/R-type/BEQ requests into RV32I words and writes them sequentially
// through a one-entry output stage. Optional immediate checks: INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input logic           clk,
  input logic           rst,
  instr_encoder_if.slave bus
);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(1) << ADDR_W;

  localparam logic [1:0] K_LW  = 2'b00;
  localparam logic [1:0] K_SW  = 2'b01;
  localparam logic [1:0] K_R   = 2'b10;
  localparam logic [1:0] K_BEQ = 2'b11;

  typedef enum logic [1:0] {S_EMPTY, S_PENDING, S_FULL} state_e;

  state_e           state_q;
  logic [31:0]      data_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  logic [31:0] word_d;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic        alu_ok;
  logic        imm_ok;
  logic        legal;
  logic        in_ready;
  logic        accept;
  logic        wr_hs;
  logic        last_hs;
  logic        unused_imm0;

  // R-type function fields; unlisted AluSel codes are illegal
  always_comb begin
    funct7 = 7'b0000000;
    funct3 = 3'b000;
    alu_ok = 1'b1;
    case (bus.AluSel)
      3'b000:  funct3 = 3'b000;
      3'b001:  begin funct7 = 7'b0100000; funct3 = 3'b000; end
      3'b010:  funct3 = 3'b111;
      3'b011:  funct3 = 3'b110;
      3'b101:  funct3 = 3'b010;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    word_d = 32'h0;
    case (bus.Kind)
      K_LW:  word_d = {bus.Imm[11:0], bus.Rs1, 3'b010, bus.Rd, 7'b0000011};
      K_SW:  word_d = {bus.Imm[11:5], bus.Rs2, bus.Rs1, 3'b010, bus.Imm[4:0], 7'b0100011};
      K_R:   word_d = {funct7, bus.Rs2, bus.Rs1, funct3, bus.Rd, 7'b0110011};
      K_BEQ: word_d = {bus.Imm[12], bus.Imm[10:5], bus.Rs2, bus.Rs1, 3'b000,
                       bus.Imm[4:1], bus.Imm[11], 7'b1100011};
      default: word_d = 32'h0;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  // Reject immediates that do not fit the encoded field
  always_comb begin
    imm_ok = 1'b1;
    case (bus.Kind)
      K_LW, K_SW: imm_ok = (bus.Imm[12] == bus.Imm[11]);
      K_BEQ:      imm_ok = !bus.Imm[0];
      default:    imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign unused_imm0 = bus.Imm[0];

  assign legal    = imm_ok & ((bus.Kind != K_R) | alu_ok);
  assign in_ready = !rst & (state_q != S_FULL) & ((state_q != S_PENDING) | bus.WrReady);
  assign accept   = bus.InValid & in_ready;
  assign wr_hs    = (state_q == S_PENDING) & bus.WrReady;
  assign last_hs  = wr_hs & (count_q == CAP - CNT_W'(1));

  // Output stage: Clear outranks both the write handshake and a new request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      data_q  <= 32'h0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (bus.Clear) begin
      state_q <= S_EMPTY;
      data_q  <= 32'h0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (wr_hs) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (accept && !legal) begin
        err_q <= 1'b1;
      end
      if (last_hs) begin
        state_q <= S_FULL;
      end else if (accept && legal) begin
        state_q <= S_PENDING;
        data_q  <= word_d;
      end else if (wr_hs) begin
        state_q <= S_EMPTY;
      end
    end
  end

  assign bus.InReady = in_ready;
  assign bus.WrValid = (state_q == S_PENDING);
  assign bus.Full    = (state_q == S_FULL);
  assign bus.WrData  = data_q;
  assign bus.WrAddr  = count_q[ADDR_W-1:0];
  assign bus.Count   = count_q;
  assign bus.Err     = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder with a small memory (ADDR_W=2)
// so the full/Clear boundary is exercised often.
module tb_instr_encoder;
  localparam int unsigned ADDR_W = 2;
  localparam int CAP = 1 << ADDR_W;

  typedef struct {
    logic [31:0]       data;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();
  instr_encoder #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  int   produced = 0;
  int   hs = 0;
  bit   err_exp = 1'b0;
  bit   pend_push = 1'b0;
  bit   pend_err = 1'b0;
  bit   flush_req = 1'b0;
  exp_t pend;
  logic [2:0] legal_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from field positions with integer arithmetic
  function automatic void model(input logic [1:0] k, input logic [2:0] a,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [12:0] imm,
                                output bit legal, output logic [31:0] w);
    int u;
    int x;
    int f3;
    int f7;
    u = int'(imm);
    legal = 1'b1;
    f3 = 0;
    f7 = 0;
    x = 0;
    case (k)
      2'd0: x = ((u & 'hFFF) << 20) | (int'(rs1) << 15) | (2 << 12) | (int'(rd) << 7) | 'h03;
      2'd1: x = (((u >> 5) & 'h7F) << 25) | (int'(rs2) << 20) | (int'(rs1) << 15) |
                (2 << 12) | ((u & 'h1F) << 7) | 'h23;
      2'd2: begin
        case (a)
          3'd0: begin f7 = 0;  f3 = 0; end
          3'd1: begin f7 = 32; f3 = 0; end
          3'd2: f3 = 7;
          3'd3: f3 = 6;
          3'd5: f3 = 2;
          default: legal = 1'b0;
        endcase
        x = (f7 << 25) | (int'(rs2) << 20) | (int'(rs1) << 15) | (f3 << 12) |
            (int'(rd) << 7) | 'h33;
      end
      default: x = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (int'(rs2) << 20) |
                   (int'(rs1) << 15) | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7) | 'h63;
    endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
    if (k == 2'd0 || k == 2'd1) begin
      if (u >= 4096) u = u - 8192;
      if (u < -2048 || u > 2047) legal = 1'b0;
    end
    if (k == 2'd3 && (u % 2) != 0) legal = 1'b0;
`endif
    w = 32'(x);
  endfunction

  // One clock of stimulus, entered and left at posedge+1
  task automatic step(input bit v, input logic [1:0] k, input logic [2:0] a,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [12:0] imm, input bit wrr, input bit clr,
                      input bit fx, input logic [31:0] fw);
    bit          legal;
    logic [31:0] w;
    if (flush_req) begin
      q.delete();
      produced  = 0;
      err_exp   = 1'b0;
      flush_req = 1'b0;
    end
    if (pend_push) q.push_back(pend);
    if (pend_err) err_exp = 1'b1;
    pend_push = 1'b0;
    pend_err  = 1'b0;
    bus.Clear = clr;   bus.InValid = v;  bus.Kind = k;   bus.AluSel = a;
    bus.Rd = rd;       bus.Rs1 = rs1;    bus.Rs2 = rs2;  bus.Imm = imm;
    bus.WrReady = wrr;
    @(negedge clk);
    if (clr) begin
      flush_req = 1'b1;
    end else if (v && bus.InReady) begin
      model(k, a, rd, rs1, rs2, imm, legal, w);
      if (!legal) begin
        pend_err = 1'b1;
      end else if (produced < CAP) begin
        pend.data = fx ? fw : w;
        pend.addr = ADDR_W'(produced);
        pend_push = 1'b1;
        produced++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit wrr);
    step(1'b0, 2'd0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0, wrr, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic clear_enc();
    step(1'b0, 2'd0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0, 1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic rand_req(input bit wrr);
    logic [2:0] a;
    a = ($urandom_range(0, 9) == 0) ? 3'b111 : legal_ops[$urandom_range(0, 4)];
    step(1'b1, 2'($urandom_range(0, 3)), a, 5'($urandom), 5'($urandom), 5'($urandom),
         13'($urandom), wrr, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: compares every presented word and the status outputs each cycle
  always @(negedge clk) begin
    if (rst || bus.Clear) begin
      hs = 0;
    end else begin
      chk("wr_valid", 32'(bus.WrValid), 32'(q.size() != 0));
      chk("count", 32'(bus.Count), 32'(hs));
      chk("full", 32'(bus.Full), 32'(hs == CAP));
      chk("err", 32'(bus.Err), 32'(err_exp));
      chk("in_ready", 32'(bus.InReady), 32'((hs != CAP) && (q.size() == 0 || bus.WrReady)));
      if (bus.WrValid && q.size() != 0) begin
        chk("wr_data", bus.WrData, q[0].data);
        chk("wr_addr", 32'(bus.WrAddr), 32'(q[0].addr));
        if (bus.WrReady) begin
          void'(q.pop_front());
          hs++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.Clear = 1'b0; bus.InValid = 1'b0; bus.Kind = 2'd0; bus.AluSel = 3'd0;
    bus.Rd = 5'd0; bus.Rs1 = 5'd0; bus.Rs2 = 5'd0; bus.Imm = 13'd0; bus.WrReady = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.InReady), 32'h0);
    chk("rst_wr_valid", 32'(bus.WrValid), 32'h0);
    chk("rst_wr_data", bus.WrData, 32'h0);
    chk("rst_count", 32'(bus.Count), 32'h0);
    chk("rst_full", 32'(bus.Full), 32'h0);
    chk("rst_err", 32'(bus.Err), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Known encodings
    step(1'b1, 2'd0, 3'd0, 5'd5, 5'd2, 5'd0, 13'd8,     1'b1, 1'b0, 1'b1, 32'h00812283);
    step(1'b1, 2'd1, 3'd0, 5'd0, 5'd2, 5'd6, 13'd12,    1'b1, 1'b0, 1'b1, 32'h00612623);
    step(1'b1, 2'd3, 3'd0, 5'd0, 5'd1, 5'd2, 13'h1FFC,  1'b1, 1'b0, 1'b1, 32'hFE208EE3);
    idle(1'b1);
    idle(1'b1);
    clear_enc();

    // ADD accepted, three stalled cycles, then SUB follows with no bubble
    step(1'b1, 2'd2, 3'b000, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1'b0, 1'b1, 32'h002081B3);
    repeat (3) step(1'b1, 2'd2, 3'b001, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1'b0, 1'b1, 32'h402081B3);
    step(1'b1, 2'd2, 3'b001, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 1'b0, 1'b1, 32'h402081B3);
    idle(1'b1);

    // Illegal AluSel
    step(1'b1, 2'd2, 3'b111, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(1'b1);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    step(1'b1, 2'd0, 3'd0, 5'd1, 5'd1, 5'd0, 13'd2048, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(1'b1);
`endif

    // Fill to capacity; the fifth request is swallowed by the full transition
    clear_enc();
    repeat (5) step(1'b1, 2'd0, 3'd0, 5'($urandom), 5'($urandom), 5'd0, 13'($urandom),
                    1'b1, 1'b0, 1'b0, 32'h0);
    idle(1'b1);
    step(1'b1, 2'd1, 3'd0, 5'd1, 5'd2, 5'd3, 13'd4, 1'b1, 1'b0, 1'b0, 32'h0);
    clear_enc();
    idle(1'b1);

    // Reset in the middle of a pending write
    step(1'b1, 2'd2, 3'b110, 5'd1, 5'd1, 5'd1, 13'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 2'd0, 3'd0, 5'd7, 5'd3, 5'd0, 13'd20, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(1'b0);
    rst = 1'b1;
    #1;
    chk("arst_wr_valid", 32'(bus.WrValid), 32'h0);
    chk("arst_wr_data", bus.WrData, 32'h0);
    chk("arst_count", 32'(bus.Count), 32'h0);
    chk("arst_err", 32'(bus.Err), 32'h0);
    chk("arst_in_ready", 32'(bus.InReady), 32'h0);
    q.delete();
    produced = 0; err_exp = 1'b0;
    pend_push = 1'b0; pend_err = 1'b0; flush_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 2'd0, 3'd0, 5'd9, 5'd4, 5'd0, 13'h1FF0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(1'b1);

    // Random traffic with random back-pressure and occasional Clear
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 3) clear_enc();
      else if ($urandom_range(0, 99) < 70) rand_req($urandom_range(0, 99) < 70);
      else idle($urandom_range(0, 99) < 70);
    end
    repeat (3) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
